// File: rtl/ssb_tx_sequencer.sv
// ssb_tx_sequencer: FIFO-to-NCO transmit sequencer for the DDS SSB chain.
// Handles prefill, the sample-rate tick (pop + load), underrun counting and
// the hang timer that unkeys the RF output.
// Ports: clk, rst_n (async, active low); fifo_empty, fifo_level, force_ptt,
// abort in; fifo_rd_en, sample_load, tx_en, state_o, underrun_cnt out.
// Optional feature: define SSB_SEQ_PREFILL_EN to enable the PREFILL state.
module ssb_tx_sequencer #(
  parameter int SAMPLE_DIV  = 2083,
  parameter int PREFILL     = 64,
  parameter int HANG_CYCLES = 20000000,
  parameter int LEVEL_W     = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fifo_empty,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               force_ptt,
  input  logic               abort,
  output logic               fifo_rd_en,
  output logic               sample_load,
  output logic               tx_en,
  output logic [1:0]         state_o,
  output logic [15:0]        underrun_cnt
);

  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int HW = $clog2(HANG_CYCLES);
  localparam logic [SW-1:0] SAMP_TC = SW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] HANG_RL = HW'(HANG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    RUN  = 2'd2,
    HANG = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [HW-1:0] hang_q, hang_d;
  logic [15:0]   urun_d;
  logic          load_d, pop_d, tx_d;
  logic          tick;
  logic          pre_go;

`ifdef SSB_SEQ_PREFILL_EN
  logic [HW-1:0] pto_q, pto_d;
  assign pre_go = (32'(fifo_level) >= 32'(PREFILL))
                || (pto_q == HANG_RL);
`else
  logic unused_cfg;
  assign unused_cfg = ^{fifo_level, 32'(PREFILL)};
  assign pre_go = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    samp_d  = '0;
    hang_d  = '0;
    urun_d  = underrun_cnt;
    load_d  = 1'b0;
    pop_d   = 1'b0;
    tick    = (samp_q == SAMP_TC);
`ifdef SSB_SEQ_PREFILL_EN
    pto_d   = '0;
`endif
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
`ifdef SSB_SEQ_PREFILL_EN
            state_d = PRE;
`else
            state_d = RUN;
`endif
          end else if (force_ptt) begin
            state_d = HANG;
            hang_d  = HANG_RL;
          end
        end
        PRE: begin
`ifdef SSB_SEQ_PREFILL_EN
          pto_d = pto_q + HW'(1);
          if (pre_go) state_d = RUN;
`else
          state_d = IDLE;
`endif
        end
        RUN: begin
          samp_d = tick ? '0 : samp_q + SW'(1);
          if (tick) begin
            load_d = 1'b1;
            if (!fifo_empty) begin
              pop_d = 1'b1;
            end else begin
              if (underrun_cnt != 16'hFFFF)
                urun_d = underrun_cnt + 16'd1;
              state_d = HANG;
              hang_d  = HANG_RL;
            end
          end
        end
        HANG: begin
          samp_d = tick ? '0 : samp_q + SW'(1);
          load_d = tick;
          // A pop beats a simultaneous hang expiry.
          if (tick && !fifo_empty) begin
            pop_d   = 1'b1;
            state_d = RUN;
          end else if (force_ptt) begin
            hang_d = HANG_RL;
          end else if (hang_q == '0) begin
            state_d = IDLE;
          end else begin
            hang_d = hang_q - HW'(1);
          end
        end
      endcase
    end
    tx_d = (state_d == RUN) || (state_d == HANG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      samp_q       <= '0;
      hang_q       <= '0;
      underrun_cnt <= '0;
      sample_load  <= 1'b0;
      fifo_rd_en   <= 1'b0;
      tx_en        <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      hang_q       <= hang_d;
      underrun_cnt <= urun_d;
      sample_load  <= load_d;
      fifo_rd_en   <= pop_d;
      tx_en        <= tx_d;
    end
  end

`ifdef SSB_SEQ_PREFILL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pto_q <= '0;
    else        pto_q <= pto_d;
  end
`endif

  assign state_o = state_q;

endmodule

// File: doc/ssb_tx_sequencer.md
# ssb_tx_sequencer

Transmit sequencer for the DDS SSB chain. It sits between the 32-bit frequency-word FIFO and the interpolator/NCO. It decides when transmission starts (prefill), generates the sample-rate tick that pops the FIFO and loads the interpolator, detects underruns, and runs the hang timer that keys the RF output off. All outputs are registered.

## Interface
Parameters:
- SAMPLE_DIV, 2083: clk cycles per audio sample. Minimum 4.
- PREFILL, 64: FIFO level required before keying up.
- HANG_CYCLES, 20000000: idle time before unkey, also the prefill timeout.
- LEVEL_W, 11: width of fifo_level.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_level  in  LEVEL_W  FIFO occupancy in words.
- force_ptt  in  1  level input; holds transmit on with no audio.
- abort  in  1  synchronous pulse; return to IDLE.
- fifo_rd_en  out  1  one-cycle FIFO pop.
- sample_load  out  1  one-cycle pulse; the interpolator starts a new segment.
- tx_en  out  1  RF gate; the NCO output is forced 0 when low.
- state_o  out  2  IDLE=0, PREFILL=1, RUN=2, HANG=3.
- underrun_cnt  out  16  saturating count of ticks taken while the FIFO was empty.

## Operation
- Reset values: state IDLE, all outputs 0, all counters 0.
- IDLE:
  - tx_en=0 and no ticks.
  - !fifo_empty goes to PREFILL.
  - force_ptt with an empty FIFO goes to HANG.
  - If both are true, !fifo_empty wins.
- PREFILL:
  - tx_en=0. The timeout counter counts up from 0.
  - fifo_level>=PREFILL goes to RUN.
  - A timeout count of HANG_CYCLES-1 also goes to RUN, so short bursts still transmit.
- RUN:
  - tx_en=1. The sample counter counts 0..SAMPLE_DIV-1 and wraps.
  - At the terminal count, the next cycle asserts sample_load.
  - If !fifo_empty at the terminal count, fifo_rd_en is asserted in the same cycle as sample_load.
  - Otherwise this is an underrun: underrun_cnt increments (saturating at 0xFFFF), there is no pop, and the state goes to HANG.
- HANG:
  - tx_en=1. Ticks continue, so sample_load keeps the interpolator holding its value.
  - The hang counter loads HANG_CYCLES-1 on entry and decrements every cycle.
  - A tick with !fifo_empty pops the FIFO and returns to RUN.
  - The counter reaching 0 with force_ptt low goes to IDLE. force_ptt high holds the counter at its reload value.
  - An empty tick in HANG is not an underrun; underrun_cnt is unchanged.
- abort:
  - Any state goes to IDLE on the next clk.
  - tx_en, fifo_rd_en and sample_load go to 0.
  - The sample, hang and timeout counters clear. underrun_cnt is kept.
  - abort has priority over every other transition.
- The sample counter resets to 0 on every entry to RUN from PREFILL or IDLE. It is not reset on HANG↔RUN, so the tick phase is continuous while keyed.
- rst_n asserted mid-operation clears everything asynchronously. No pop is issued after rst_n is asserted.

## Timing
- The condition is sampled at edge t, and state_o plus tx_en change at t+1.
- First tick after entering RUN:
  - The counter terminal value is reached SAMPLE_DIV-1 cycles after entry.
  - sample_load/fifo_rd_en pulse at entry + SAMPLE_DIV.
  - Pulses then repeat every SAMPLE_DIV cycles.
- fifo_rd_en is never high for 2 consecutive cycles. The FIFO's data is valid in the cycle after fifo_rd_en; that is the consumer's concern.
- Unkey: tx_en falls at the cycle the hang counter expires + 1, i.e. HANG_CYCLES cycles after HANG entry.
- Simultaneous events:
  - A tick and hang expiry in the same cycle: the tick's pop wins, and the state goes to RUN.
  - A prefill threshold and timeout in the same cycle: the state goes to RUN (identical outcome).

## Configuration
- SSB_SEQ_PREFILL_EN defined: the PREFILL state behaves as above.
- SSB_SEQ_PREFILL_EN undefined: the PREFILL state and its timeout counter are removed. IDLE with !fifo_empty goes directly to RUN. state_o never reads 1. The PREFILL parameter is ignored.

## Test plan
All tests use SAMPLE_DIV=8, PREFILL=4, HANG_CYCLES=20, with the macro defined unless stated.
- Reset and level: hold rst_n=0, then release with fifo_empty=1 → all outputs 0 and state_o=0 indefinitely.
- Prefill to RUN: set fifo_empty=0, then ramp fifo_level 1→4 → state_o=1 until level 4 is sampled, then 2 with tx_en=1. sample_load and fifo_rd_en pulse together 8 cycles after RUN entry, then every 8 cycles.
- Underrun and hang: in RUN, set fifo_empty=1 before a tick → sample_load without fifo_rd_en, underrun_cnt=1, state_o=3. tx_en falls 20 cycles later, and state_o=0.
- Recovery in HANG: set fifo_empty=0 before the second HANG tick → fifo_rd_en at that tick, state_o=2, tick spacing still 8, underrun_cnt unchanged.
- Abort and force_ptt:
  - force_ptt=1 from IDLE with the FIFO empty → HANG with tx_en=1 held for over 100 cycles.
  - An abort pulse then gives state_o=0 and tx_en=0 the next cycle.
- Macro undefined: fifo_empty=0 with fifo_level=1 → state_o goes 0→2 directly. The first pop occurs 8 cycles after RUN entry.
